// File: rtl/keycode_event_queue.sv
// keycode_event_queue
//   Turns the Nios keycode PIO word (two USB HID key slots) into a stream of
//   press/release events for the game logic. The raw word is first filtered
//   until it has been steady for STABLE_CYCLES cycles. Each accepted report is
//   then compared against the previous one, and the differences are serialized
//   into a show-ahead FIFO. Movement-key state is kept as a held-key bitmap.
//
// Parameters
//   STABLE_CYCLES  consecutive identical samples needed to accept (2..255)
//   DEPTH          event FIFO entries, power of two (2..64)
//
// Ports
//   Clk        system clock
//   Reset_n    asynchronous active-low reset
//   Keycode    [7:0] slot0 HID code, [15:8] slot1 HID code, 0x00 = empty
//   evt_ready  consumer takes the head event this cycle
//   ovf_clr    clears the sticky overflow flag
//   evt_valid  FIFO holds at least one event
//   evt_code   HID code of the head event
//   evt_press  1 = press, 0 = release (head event)
//   evt_count  FIFO occupancy
//   held       {space, D, S, A, W}, set while the code is in the accepted report
//   overflow   sticky: an event was dropped because the FIFO was full

module keycode_event_queue #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned DEPTH         = 8
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [15:0]              Keycode,
  input  logic                     evt_ready,
  input  logic                     ovf_clr,
  output logic                     evt_valid,
  output logic [7:0]               evt_code,
  output logic                     evt_press,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic [4:0]               held,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [7:0]  StableMax = 8'(STABLE_CYCLES);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  // Held-key bitmap order: bit0 W, bit1 A, bit2 S, bit3 D, bit4 space.
  function automatic logic [4:0] decode_held(input logic [15:0] rep);
    logic [4:0] h;
    h    = '0;
    h[0] = (rep[7:0] == 8'h1A) || (rep[15:8] == 8'h1A);
    h[1] = (rep[7:0] == 8'h04) || (rep[15:8] == 8'h04);
    h[2] = (rep[7:0] == 8'h16) || (rep[15:8] == 8'h16);
    h[3] = (rep[7:0] == 8'h07) || (rep[15:8] == 8'h07);
    h[4] = (rep[7:0] == 8'h2C) || (rep[15:8] == 8'h2C);
    return h;
  endfunction

  // Registers
  logic [15:0] keycode_q,     keycode_d;
  logic [7:0]  stab_cnt_q,    stab_cnt_d;
  logic [15:0] acc_report_q,  acc_report_d;
  logic [15:0] prev_report_q, prev_report_d;
  logic [4:0]  held_q,        held_d;
  state_e      state_q,       state_d;
  logic [1:0]  idx_q,         idx_d;
  logic [AW-1:0] wptr_q,      wptr_d;
  logic [AW-1:0] rptr_q,      rptr_d;
  logic [AW:0]   count_q,     count_d;
  logic        ovf_q,         ovf_d;
  logic [8:0]  mem [DEPTH];

  // Combinational
  logic        stable;
  logic        accept;
  logic [7:0]  cand_code;
  logic        cand_press;
  logic        cand_ok;
  logic        fifo_full;
  logic        fifo_nonempty;
  logic        pop;
  logic        push;
  logic        drop;
  logic [8:0]  head;

  // Stability filter
  always_comb begin
    keycode_d  = Keycode;
    stable     = (stab_cnt_q == StableMax);
    stab_cnt_d = stab_cnt_q;
    if (Keycode != keycode_q) begin
      stab_cnt_d = '0;
    end else if (!stable) begin
      stab_cnt_d = stab_cnt_q + 8'd1;
    end
    // Also require this cycle's word to match the last sample, so a glitch that
    // lands right after saturation is never taken as the new report.
    accept = (state_q == StIdle) && stable && (Keycode == keycode_q) &&
             (Keycode != acc_report_q);
  end

  // Report tracking and EMIT sequencer
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_report_d  = acc_report_q;
    prev_report_d = prev_report_q;
    held_d        = held_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          prev_report_d = acc_report_q;
          acc_report_d  = Keycode;
          held_d        = decode_held(Keycode);
          state_d       = StEmit;
          idx_d         = 2'd0;
        end
      end
      StEmit: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // One diff candidate per EMIT cycle: releases of old slots, then presses of
  // new slots. acc_report_q already holds the new report while emitting.
  always_comb begin
    logic [7:0] p0, p1, n0, n1;
    p0         = prev_report_q[7:0];
    p1         = prev_report_q[15:8];
    n0         = acc_report_q[7:0];
    n1         = acc_report_q[15:8];
    cand_code  = '0;
    cand_press = 1'b0;
    cand_ok    = 1'b0;
    if (state_q == StEmit) begin
      case (idx_q)
        2'd0: begin
          cand_code = p0;
          cand_ok   = (p0 != 8'h00) && (p0 != n0) && (p0 != n1);
        end
        2'd1: begin
          cand_code = p1;
          cand_ok   = (p1 != 8'h00) && (p1 != n0) && (p1 != n1) && (p1 != p0);
        end
        2'd2: begin
          cand_code  = n0;
          cand_press = 1'b1;
          cand_ok    = (n0 != 8'h00) && (n0 != p0) && (n0 != p1);
        end
        2'd3: begin
          cand_code  = n1;
          cand_press = 1'b1;
          cand_ok    = (n1 != 8'h00) && (n1 != p0) && (n1 != p1) && (n1 != n0);
        end
      endcase
    end
  end

  // Event FIFO control
  always_comb begin
    fifo_full     = (count_q == FullCount);
    fifo_nonempty = (count_q != '0);
    pop           = fifo_nonempty && evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push          = cand_ok && (!fifo_full || pop);
    drop          = cand_ok && fifo_full && !pop;

    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    // Set wins over clear.
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    head      = mem[rptr_q];
    evt_valid = fifo_nonempty;
    evt_code  = fifo_nonempty ? head[7:0] : 8'h00;
    evt_press = fifo_nonempty ? head[8]   : 1'b0;
    evt_count = count_q;
    held      = held_q;
    overflow  = ovf_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      keycode_q     <= '0;
      stab_cnt_q    <= '0;
      acc_report_q  <= '0;
      prev_report_q <= '0;
      held_q        <= '0;
      state_q       <= StIdle;
      idx_q         <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
    end else begin
      keycode_q     <= keycode_d;
      stab_cnt_q    <= stab_cnt_d;
      acc_report_q  <= acc_report_d;
      prev_report_q <= prev_report_d;
      held_q        <= held_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wptr_q] <= {cand_press, cand_code};
    end
  end

endmodule

// File: tb/tb_keycode_event_queue.sv
module tb_keycode_event_queue;

  localparam int S = 4;
  localparam int D = 8;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [15:0] Keycode;
  logic        evt_ready;
  logic        ovf_clr;
  logic        evt_valid;
  logic [7:0]  evt_code;
  logic        evt_press;
  logic [3:0]  evt_count;
  logic [4:0]  held;
  logic        overflow;

  keycode_event_queue #(.STABLE_CYCLES(S), .DEPTH(D)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Keycode   (Keycode),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_press (evt_press),
    .evt_count (evt_count),
    .held      (held),
    .overflow  (overflow)
  );

  always #10 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Event = {press, code}. A report change schedules four slots up front; each
  // cycle of emission consumes one slot.
  typedef struct packed {
    logic       ok;
    logic [8:0] ev;
  } slot_t;

  slot_t       sched[$];
  logic [8:0]  fifo[$];
  logic [8:0]  got[$];
  int          m_cnt;
  logic [15:0] m_kq, m_acc;
  logic [4:0]  m_held;
  logic        m_ovf;

  function automatic logic [4:0] held_of(input logic [15:0] r);
    logic [7:0] codes [5];
    logic [4:0] h;
    codes = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C};
    h = '0;
    for (int i = 0; i < 5; i++) h[i] = (r[7:0] == codes[i]) || (r[15:8] == codes[i]);
    return h;
  endfunction

  task automatic model_reset();
    sched.delete();
    fifo.delete();
    m_cnt = 0; m_kq = '0; m_acc = '0; m_held = '0; m_ovf = 1'b0;
  endtask

  task automatic schedule(input logic [15:0] p, input logic [15:0] n);
    slot_t s;
    logic [7:0] p0, p1, n0, n1;
    p0 = p[7:0]; p1 = p[15:8]; n0 = n[7:0]; n1 = n[15:8];
    s.ok = (p0 != 0) && (p0 != n0) && (p0 != n1);               s.ev = {1'b0, p0};
    sched.push_back(s);
    s.ok = (p1 != 0) && (p1 != n0) && (p1 != n1) && (p1 != p0); s.ev = {1'b0, p1};
    sched.push_back(s);
    s.ok = (n0 != 0) && (n0 != p0) && (n0 != p1);               s.ev = {1'b1, n0};
    sched.push_back(s);
    s.ok = (n1 != 0) && (n1 != p0) && (n1 != p1) && (n1 != n0); s.ev = {1'b1, n1};
    sched.push_back(s);
  endtask

  task automatic model_step(input logic [15:0] kc, input logic rdy, input logic clr);
    bit idle, stable, drop;
    slot_t s;
    logic [8:0] e;
    idle   = (sched.size() == 0);
    stable = (m_cnt == S);
    drop   = 0;
    if (fifo.size() > 0 && rdy) e = fifo.pop_front();
    if (!idle) begin
      s = sched.pop_front();
      if (s.ok) begin
        if (fifo.size() < D) fifo.push_back(s.ev);
        else drop = 1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (idle && stable && kc == m_kq && kc != m_acc) begin
      schedule(m_acc, kc);
      m_acc  = kc;
      m_held = held_of(kc);
    end
    if (kc != m_kq) m_cnt = 0;
    else if (m_cnt < S) m_cnt++;
    m_kq = kc;
  endtask

  // One clock: drive at negedge, advance model, compare at the next negedge.
  task automatic cycle(input logic [15:0] kc, input logic rdy, input logic clr);
    Keycode = kc; evt_ready = rdy; ovf_clr = clr;
    if (evt_valid && rdy) got.push_back({evt_press, evt_code});
    model_step(kc, rdy, clr);
    @(posedge Clk);
    @(negedge Clk);
    chk("evt_valid", 32'(evt_valid), 32'(fifo.size() > 0));
    chk("evt_count", 32'(evt_count), 32'(fifo.size()));
    if (fifo.size() > 0) begin
      chk("evt_code",  32'(evt_code),  32'(fifo[0][7:0]));
      chk("evt_press", 32'(evt_press), 32'(fifo[0][8]));
    end
    chk("held",     32'(held),     32'(m_held));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic run(input logic [15:0] kc, input logic rdy, input logic clr, input int n);
    for (int i = 0; i < n; i++) cycle(kc, rdy, clr);
  endtask

  // Ready only on cycles where a qualifying event is being pushed.
  task automatic run_push_ready(input logic [15:0] kc, input int n);
    for (int i = 0; i < n; i++) cycle(kc, (sched.size() > 0) && sched[0].ok, 1'b0);
  endtask

  function automatic logic [7:0] pick_code();
    case ($urandom_range(0, 7))
      2:       return 8'h1A;
      3:       return 8'h04;
      4:       return 8'h16;
      5:       return 8'h07;
      6:       return 8'h2C;
      7:       return 8'($urandom_range(1, 255));
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    int lat;
    logic [8:0] exp4 [4];
    logic [8:0] exp10 [10];

    Reset_n = 1'b0; Keycode = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    #5;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_count", 32'(evt_count), 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    // Idle after reset
    run(16'h0000, 1'b0, 1'b0, 20);
    chk("idle_valid", 32'(evt_valid), 0);
    chk("idle_held",  32'(held),      0);
    chk("idle_ovf",   32'(overflow),  0);
    chk("idle_count", 32'(evt_count), 0);

    // First press: sample + S to saturate + accept + three emit slots to idx2
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(16'h001A, 1'b0, 1'b0);
      if (evt_valid && lat == 0) lat = i;
    end
    chk("first_latency", 32'(lat), 32'(S + 5));
    chk("w_code",  32'(evt_code),  32'h1A);
    chk("w_press", 32'(evt_press), 1);
    chk("w_held",  32'(held),      32'b00001);
    chk("w_count", 32'(evt_count), 1);

    // W released, A and D pressed
    got.delete();
    run(16'h0704, 1'b0, 1'b0, 12);
    chk("ad_count", 32'(evt_count), 4);
    chk("ad_held",  32'(held),      32'b01010);
    run(16'h0704, 1'b1, 1'b0, 6);
    exp4 = '{9'h11A, 9'h01A, 9'h104, 9'h107};
    chk("ad_npop", 32'(got.size()), 4);
    for (int i = 0; i < 4; i++) chk("ad_order", 32'(got[i]), 32'(exp4[i]));

    // Glitching input produces nothing; settling gives one release
    run(16'h0016, 1'b1, 1'b0, 14);
    got.delete();
    for (int i = 0; i < 10; i++) begin
      run(16'h0004, 1'b0, 1'b0, 2);
      run(16'h0016, 1'b0, 1'b0, 2);
    end
    chk("glitch_count", 32'(evt_count), 0);
    run(16'h0000, 1'b0, 1'b0, 14);
    chk("settle_count", 32'(evt_count), 1);
    chk("settle_code",  32'(evt_code),  32'h16);
    chk("settle_press", 32'(evt_press), 0);
    chk("settle_held",  32'(held),      0);
    run(16'h0000, 1'b1, 1'b0, 3);

    // Overflow: 10 events into 8 entries
    got.delete();
    run(16'h0201, 1'b0, 1'b0, 12);
    run(16'h0403, 1'b0, 1'b0, 12);
    run(16'h0605, 1'b0, 1'b0, 12);
    chk("ovf_count", 32'(evt_count), 8);
    chk("ovf_flag",  32'(overflow),  1);
    run(16'h0605, 1'b0, 1'b1, 1);
    chk("ovf_clr", 32'(overflow), 0);

    // Full FIFO with a pop on each push cycle: no loss
    run_push_ready(16'h0000, 12);
    chk("full_count", 32'(evt_count), 8);
    chk("full_ovf",   32'(overflow),  0);
    run(16'h0000, 1'b1, 1'b0, 10);
    exp10 = '{9'h101, 9'h102, 9'h001, 9'h002, 9'h103, 9'h104,
              9'h003, 9'h004, 9'h005, 9'h006};
    chk("ovf_npop", 32'(got.size()), 10);
    for (int i = 0; i < 10; i++) chk("ovf_order", 32'(got[i]), 32'(exp10[i]));

    // Same code in both slots
    run(16'h2C2C, 1'b0, 1'b0, 12);
    chk("dup_count", 32'(evt_count), 1);
    chk("dup_code",  32'(evt_code),  32'h2C);
    chk("dup_press", 32'(evt_press), 1);
    chk("dup_held",  32'(held),      32'b10000);

    // Reset in the middle of emission
    for (int i = 0; i < 20; i++) begin
      if (sched.size() == 2) break;
      cycle(16'h0016, 1'b0, 1'b0);
    end
    chk("mid_emit_reached", 32'(sched.size()), 2);
    #2 Reset_n = 1'b0;
    #1;
    chk("mr_valid", 32'(evt_valid), 0);
    chk("mr_code",  32'(evt_code),  0);
    chk("mr_press", 32'(evt_press), 0);
    chk("mr_count", 32'(evt_count), 0);
    chk("mr_held",  32'(held),      0);
    chk("mr_ovf",   32'(overflow),  0);
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Randomized traffic against the model
    for (int seg = 0; seg < 400; seg++) begin
      logic [15:0] kc;
      int hold, rp;
      kc   = {pick_code(), pick_code()};
      hold = $urandom_range(1, 12);
      case ($urandom_range(0, 2))
        0:       rp = 10;
        1:       rp = 60;
        default: rp = 95;
      endcase
      for (int c = 0; c < hold; c++)
        cycle(kc, $urandom_range(0, 99) < rp, $urandom_range(0, 99) < 5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
